fwd_hazard_ctrl: RTL and testbench

Pipeline controller for the 8-bit, 32-entry register bank and its operand-forwarding muxes. It decodes each 24-bit instruction leaving fetch and tracks destination tags through EX/DM/WB. It drives the bank's forwarding selects (`mux_sel_A`, `mux_sel_B`), immediate select and DM write address. It also inserts a one-cycle bubble on load-use hazards and squashes younger instructions on flush.

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/fwd_sel_unit.sv | 36 +++
 rtl/fwd_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode constants, instruction field ranges, forwarding-select encoding,
// the destination-tag record and the hazard FSM states for the pipeline controller.
package mips_pkg;

  localparam int NREG = 32;
  localparam int TW   = $clog2(NREG);
  localparam int IW   = 24;

  localparam int FLD_OP_HI  = 23;
  localparam int FLD_OP_LO  = 19;
  localparam int FLD_RD_HI  = 18;
  localparam int FLD_RD_LO  = 14;
  localparam int FLD_RS1_HI = 13;
  localparam int FLD_RS1_LO = 9;
  localparam int FLD_RS2_HI = 8;
  localparam int FLD_RS2_LO = 4;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b01100;
  localparam logic [4:0] OP_STORE = 5'b01101;

  localparam logic [1:0] SEL_BANK = 2'd0;
  localparam logic [1:0] SEL_EX   = 2'd1;
  localparam logic [1:0] SEL_DM   = 2'd2;
  localparam logic [1:0] SEL_WB   = 2'd3;

  typedef struct packed {
    logic          wr;
    logic          is_load;
    logic [TW-1:0] rd;
  } tag_t;

  localparam tag_t TAG_NOP = '{wr: 1'b0, is_load: 1'b0, rd: '0};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } fsm_state_e;

  // r0 is hard-wired, so an instruction targeting it never counts as a write.
  function automatic tag_t decode_tag(input logic [4:0] op, input logic [TW-1:0] rd);
    tag_t t;
    t.rd      = rd;
    t.is_load = (op == OP_LOAD);
    t.wr      = (op != OP_NOP) && (op != OP_STORE) && (rd != '0);
    return t;
  endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one source operand against the EX/DM/WB destination tags;
// the nearest matching producer wins.
module fwd_sel_unit
  import mips_pkg::*;
(
  input  logic [TW-1:0] src,
  input  logic          ex_wr,
  input  logic [TW-1:0] ex_rd,
  input  logic          dm_wr,
  input  logic [TW-1:0] dm_rd,
  input  logic          wb_wr,
  input  logic [TW-1:0] wb_rd,
  output logic [1:0]    sel
);

  logic ex_hit;
  logic dm_hit;
  logic wb_hit;

  assign ex_hit = ex_wr && (ex_rd != '0) && (ex_rd == src);
  assign dm_hit = dm_wr && (dm_rd != '0) && (dm_rd == src);
  assign wb_hit = wb_wr && (wb_rd != '0) && (wb_rd == src);

  always_comb begin
    // NOTE: default assigned first so every path drives sel and no latch is inferred.
    sel = SEL_BANK;
    if (ex_hit) begin
      sel = SEL_EX;
    end else if (dm_hit) begin
      sel = SEL_DM;
    end else if (wb_hit) begin
      sel = SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Pipeline controller: decodes the ID instruction, tracks destination tags through
// EX/DM/WB, registers forwarding selects, and handles load-use bubbles and flushes.
module fwd_hazard_ctrl
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] ins_in,
  input  logic          ins_valid,
  input  logic          flush,
  output logic [IW-1:0] ins,
  output logic          stall,
  output logic [1:0]    mux_sel_A,
  output logic [1:0]    mux_sel_B,
  output logic          imm_sel,
  output logic [TW-1:0] RW_dm,
  output logic          wr_en_dm
);

  logic [IW-1:0] ins_q, ins_d;
  tag_t          ex_tag_q, ex_tag_d;
  tag_t          dm_tag_q, dm_tag_d;
  tag_t          wb_tag_q, wb_tag_d;
  logic [1:0]    sel_a_q, sel_a_d;
  logic [1:0]    sel_b_q, sel_b_d;
  logic          imm_q, imm_d;
  fsm_state_e    state_q, state_d;

  logic [4:0]    id_op;
  logic [TW-1:0] id_rd, id_rs1, id_rs2;
  logic          id_imm;
  tag_t          id_tag;
  logic [1:0]    sel_a_raw, sel_b_raw;
  logic          load_use;
  logic          squash;
  logic          unused_load_bits;

  assign id_op  = ins_q[FLD_OP_HI:FLD_OP_LO];
  assign id_rd  = ins_q[FLD_RD_HI:FLD_RD_LO];
  assign id_rs1 = ins_q[FLD_RS1_HI:FLD_RS1_LO];
  assign id_rs2 = ins_q[FLD_RS2_HI:FLD_RS2_LO];
  assign id_imm = id_op[4];
  assign id_tag = decode_tag(id_op, id_rd);

  fwd_sel_unit u_sel_a (
    .src   (id_rs1),
    .ex_wr (ex_tag_q.wr),
    .ex_rd (ex_tag_q.rd),
    .dm_wr (dm_tag_q.wr),
    .dm_rd (dm_tag_q.rd),
    .wb_wr (wb_tag_q.wr),
    .wb_rd (wb_tag_q.rd),
    .sel   (sel_a_raw)
  );

  fwd_sel_unit u_sel_b (
    .src   (id_rs2),
    .ex_wr (ex_tag_q.wr),
    .ex_rd (ex_tag_q.rd),
    .dm_wr (dm_tag_q.wr),
    .dm_rd (dm_tag_q.rd),
    .wb_wr (wb_tag_q.wr),
    .wb_rd (wb_tag_q.rd),
    .sel   (sel_b_raw)
  );

  always_comb begin
    // A load hit in EX is exactly an EX-forward request that the load cannot yet satisfy.
    load_use = ex_tag_q.is_load &&
               ((sel_a_raw == SEL_EX) || (!id_imm && (sel_b_raw == SEL_EX)));
    stall    = load_use && (state_q == ST_RUN) && !flush;
    squash   = stall || flush;

    state_d = state_q;
    case (state_q)
      ST_RUN:    if (stall) state_d = ST_BUBBLE;
      ST_BUBBLE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    if (flush) state_d = ST_RUN;

    // Flush kills the younger ID instruction; a stall re-presents it next cycle.
    ins_d = flush ? '0 : (stall ? ins_q : (ins_valid ? ins_in : '0));

    ex_tag_d = squash ? TAG_NOP : id_tag;
    dm_tag_d = ex_tag_q;
    wb_tag_d = dm_tag_q;

    sel_a_d = squash ? SEL_BANK : sel_a_raw;
    sel_b_d = squash ? SEL_BANK : sel_b_raw;
    imm_d   = squash ? 1'b0 : id_imm;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ins_q    <= '0;
      ex_tag_q <= TAG_NOP;
      dm_tag_q <= TAG_NOP;
      wb_tag_q <= TAG_NOP;
      sel_a_q  <= SEL_BANK;
      sel_b_q  <= SEL_BANK;
      imm_q    <= 1'b0;
      state_q  <= ST_RUN;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      ins_q    <= ins_d;
      ex_tag_q <= ex_tag_d;
      dm_tag_q <= dm_tag_d;
      wb_tag_q <= wb_tag_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      imm_q    <= imm_d;
      state_q  <= state_d;
    end
  end

  assign ins       = ins_q;
  assign mux_sel_A = sel_a_q;
  assign mux_sel_B = sel_b_q;
  assign imm_sel   = imm_q;
  assign RW_dm     = dm_tag_q.rd;
  assign wr_en_dm  = dm_tag_q.wr;

  // Load flags only matter while the producer sits in EX.
  assign unused_load_bits = dm_tag_q.is_load ^ wb_tag_q.is_load;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus randomized traffic, both checked
// against a stage-list reference model of the forwarding and hazard rules.
module tb_fwd_hazard_ctrl;
  import mips_pkg::*;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b10001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] ins_in;
  logic          ins_valid;
  logic          flush;
  logic [IW-1:0] ins;
  logic          stall;
  logic [1:0]    mux_sel_A;
  logic [1:0]    mux_sel_B;
  logic          imm_sel;
  logic [TW-1:0] RW_dm;
  logic          wr_en_dm;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ins_in    (ins_in),
    .ins_valid (ins_valid),
    .flush     (flush),
    .ins       (ins),
    .stall     (stall),
    .mux_sel_A (mux_sel_A),
    .mux_sel_B (mux_sel_B),
    .imm_sel   (imm_sel),
    .RW_dm     (RW_dm),
    .wr_en_dm  (wr_en_dm)
  );

  typedef struct {
    bit wr;
    bit ld;
    int rd;
  } mtag_t;

  // Reference pipeline: index 0 = EX, 1 = DM, 2 = WB.
  mtag_t         m_pipe[3];
  logic [IW-1:0] m_id;
  int            m_sel_a, m_sel_b, m_imm;
  bit            m_known = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_dist[4] = '{1, 2, 3, 0};

  int c_ins, c_stall, c_sel_a, c_sel_b, c_imm, c_rw, c_wr;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic mtag_t m_decode(input logic [IW-1:0] i);
    mtag_t t;
    int op;
    op   = int'(i[23:19]);
    t.rd = int'(i[18:14]);
    t.ld = (op == 12);
    t.wr = (op != 0) && (op != 13) && (t.rd != 0);
    return t;
  endfunction

  function automatic int m_fwd(input int s);
    for (int k = 0; k < 3; k++)
      if (m_pipe[k].wr && m_pipe[k].rd != 0 && m_pipe[k].rd == s) return k + 1;
    return 0;
  endfunction

  // One clock: drive inputs, check outputs at the falling edge, advance the model.
  task automatic step(input logic [IW-1:0] i, input bit v, input bit f, input bit r);
    mtag_t nop_t = '{wr: 1'b0, ld: 1'b0, rd: 0};
    mtag_t ex;
    int    rs1, rs2, na, nb;
    bit    imm, exp_stall;
    ins_in    = i;
    ins_valid = v;
    flush     = f;
    rst_n     = r;
    @(negedge clk);
    c_ins   = int'(ins);
    c_stall = int'(stall);
    c_sel_a = int'(mux_sel_A);
    c_sel_b = int'(mux_sel_B);
    c_imm   = int'(imm_sel);
    c_rw    = int'(RW_dm);
    c_wr    = int'(wr_en_dm);
    rs1 = int'(m_id[13:9]);
    rs2 = int'(m_id[8:4]);
    imm = m_id[23];
    ex  = m_pipe[0];
    exp_stall = ex.ld && ex.wr && ex.rd != 0 &&
                (ex.rd == rs1 || (!imm && ex.rd == rs2)) && !f;
    if (m_known) begin
      check("ins",       c_ins,   int'(m_id));
      check("stall",     c_stall, int'(exp_stall));
      check("mux_sel_A", c_sel_a, m_sel_a);
      check("mux_sel_B", c_sel_b, m_sel_b);
      check("imm_sel",   c_imm,   m_imm);
      check("RW_dm",     c_rw,    m_pipe[1].rd);
      check("wr_en_dm",  c_wr,    int'(m_pipe[1].wr));
    end
    if (!r) begin
      m_known = 1'b1;
      m_id    = '0;
      for (int k = 0; k < 3; k++) m_pipe[k] = nop_t;
      m_sel_a = 0;
      m_sel_b = 0;
      m_imm   = 0;
    end else begin
      na = m_fwd(rs1);
      nb = m_fwd(rs2);
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = (exp_stall || f) ? nop_t : m_decode(m_id);
      m_sel_a   = (exp_stall || f) ? 0 : na;
      m_sel_b   = (exp_stall || f) ? 0 : nb;
      m_imm     = (exp_stall || f) ? 0 : int'(imm);
      if (f)               m_id = '0;
      else if (!exp_stall) m_id = v ? i : '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ins_in    = '0;
    ins_valid = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);
    check("rst_ins",   c_ins,   0);
    check("rst_stall", c_stall, 0);
    check("rst_sel_a", c_sel_a, 0);
    check("rst_sel_b", c_sel_b, 0);
    check("rst_wr_dm", c_wr,    0);

    // Back-to-back EX forward
    nops(3);
    step(mk(OP_ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1);
    step(mk(OP_ADD, 5'd5, 5'd3, 5'd4), 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    check("b2b_stall", c_stall, 0);
    step('0, 1'b1, 1'b0, 1'b1);
    check("b2b_sel_a", c_sel_a, 1);
    check("b2b_sel_b", c_sel_b, 0);

    // Producer distance 0..3 NOPs
    for (int n = 0; n < 4; n++) begin
      nops(3);
      step(mk(OP_ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1);
      nops(n);
      step(mk(OP_SUB, 5'd6, 5'd2, 5'd3), 1'b1, 1'b0, 1'b1);
      nops(2);
      check($sformatf("dist%0d_sel_b", n), c_sel_b, exp_dist[n]);
      check($sformatf("dist%0d_sel_a", n), c_sel_a, 0);
    end

    // Load-use bubble
    nops(3);
    step(mk(OP_LOAD, 5'd7, 5'd2, 5'd0), 1'b1, 1'b0, 1'b1);
    step(mk(OP_ADD, 5'd1, 5'd7, 5'd7), 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    check("lu_stall", c_stall, 1);
    step('0, 1'b1, 1'b0, 1'b1);
    check("lu_held_ins", c_ins,   int'(mk(OP_ADD, 5'd1, 5'd7, 5'd7)));
    check("lu_stall_end", c_stall, 0);
    check("lu_wr_1",      c_wr,    1);
    check("lu_rw_load",   c_rw,    7);
    step('0, 1'b1, 1'b0, 1'b1);
    check("lu_sel_a", c_sel_a, 2);
    check("lu_sel_b", c_sel_b, 2);
    check("lu_wr_2",  c_wr,    0);
    step('0, 1'b1, 1'b0, 1'b1);
    check("lu_wr_3",  c_wr,    1);
    check("lu_rw_add", c_rw,   1);

    // Load followed by immediate form reading the load target only through rs2
    nops(3);
    step(mk(OP_LOAD, 5'd7, 5'd2, 5'd0), 1'b1, 1'b0, 1'b1);
    step(mk(OP_ADDI, 5'd1, 5'd2, 5'd7), 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    check("imm_no_stall", c_stall, 0);
    step('0, 1'b1, 1'b0, 1'b1);
    check("imm_sel", c_imm,   1);
    check("imm_sel_a", c_sel_a, 0);
    check("imm_sel_b", c_sel_b, 1);

    // r0 never writes nor forwards
    nops(3);
    step(mk(OP_ADD, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1);
    step(mk(OP_ADD, 5'd2, 5'd0, 5'd0), 1'b1, 1'b0, 1'b1);
    nops(2);
    check("r0_sel_a", c_sel_a, 0);
    check("r0_sel_b", c_sel_b, 0);
    check("r0_wr_dm", c_wr,    0);

    // Flush wins over a load-use stall
    nops(3);
    step(mk(OP_LOAD, 5'd7, 5'd2, 5'd0), 1'b1, 1'b0, 1'b1);
    step(mk(OP_ADD, 5'd1, 5'd7, 5'd7), 1'b1, 1'b0, 1'b1);
    step(mk(OP_ADD, 5'd4, 5'd5, 5'd6), 1'b1, 1'b1, 1'b1);
    check("fl_stall", c_stall, 0);
    step('0, 1'b1, 1'b0, 1'b1);
    check("fl_ins",   c_ins,   0);
    check("fl_sel_a", c_sel_a, 0);
    check("fl_sel_b", c_sel_b, 0);
    check("fl_wr_dm", c_wr,    1);

    // Reset during the bubble cycle
    nops(3);
    step(mk(OP_LOAD, 5'd7, 5'd2, 5'd0), 1'b1, 1'b0, 1'b1);
    step(mk(OP_ADD, 5'd1, 5'd7, 5'd7), 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b1);
    check("rb_ins",   c_ins,   0);
    check("rb_stall", c_stall, 0);
    check("rb_sel_a", c_sel_a, 0);
    check("rb_sel_b", c_sel_b, 0);
    check("rb_imm",   c_imm,   0);
    check("rb_rw",    c_rw,    0);
    check("rb_wr",    c_wr,    0);

    // Randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      logic [4:0]    op;
      logic [IW-1:0] i;
      int            pick;
      pick = int'($urandom_range(0, 9));
      case (pick)
        0:       op = OP_NOP;
        1, 2, 3: op = OP_LOAD;
        4:       op = OP_STORE;
        5, 6:    op = {1'b1, 4'($urandom)};
        default: op = {1'b0, 4'($urandom_range(1, 11))};
      endcase
      i = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7))) | 24'($urandom_range(0, 15));
      step(i, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
